wb_commit_unit: RTL and testbench
=================================

Name: wb_commit_unit

Overview:
- Write-back commit unit: the write side of the 8x16 register file.
- Accepts results from the ALU and from load/memory over valid/ready handshakes and arbitrates between them.
- Buffers accepted results in a small in-order queue and drives the register file's RW/WD/RegWrite/rf_enable inputs, one write per cycle.
- Optionally forwards pending (not yet committed) values to the decode read ports.

Parameters:
- DATA_W, 16, result/register data width.
- ADDR_W, 3, register address width (8 registers).
- DEPTH, 4, commit queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result present.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid is also high.
- mem_valid  in  1  load result present.
- mem_rd  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load data.
- mem_ready  out  1  load result accepted this cycle when mem_valid is also high.
- rf_busy  in  1  register-file write port unavailable this cycle; commit stalls.
- flush  in  1  synchronous discard of all queued writes.
- RegWrite  out  1  register-file write enable (registered).
- rf_enable  out  1  register-file enable (registered; equals RegWrite).
- RW  out  ADDR_W  register-file write address (registered).
- WD  out  DATA_W  register-file write data (registered).
- fwd_ra  in  ADDR_W  decode read address A.
- fwd_rb  in  ADDR_W  decode read address B.
- fwd_a_hit  out  1  a pending write targets fwd_ra.
- fwd_a_data  out  DATA_W  youngest pending value for fwd_ra.
- fwd_b_hit  out  1  a pending write targets fwd_rb.
- fwd_b_data  out  DATA_W  youngest pending value for fwd_rb.
- wb_count  out  clog2(DEPTH)+1  queue occupancy.
- wb_empty  out  1  queue empty and no write on RegWrite this cycle.

Behaviour:
- Reset (rst low, asynchronous): queue cleared, pointers and count 0, RegWrite/rf_enable 0, RW 0, WD 0, grant state MEM_PRI.
- Arbitration: at most one push per cycle.
  - If only one source is valid, that source wins.
  - If both are valid, the winner follows a 2-state FSM: MEM_PRI grants mem; ALU_PRI grants alu.
  - After a contended grant, the FSM moves to the other state. Uncontended grants leave it unchanged.
- Ready: the granted source's ready = (count<DEPTH) OR (pop this cycle). The loser's ready = 0. Ready is combinational from valid, count, rf_busy and flush.
- A result whose rd = 0 is accepted (ready high) but never enqueued. R0 is never written.
- Pop: when the queue is not empty and rf_busy=0, the head is popped.
  - Next cycle: RegWrite=rf_enable=1, RW=head rd, WD=head data.
  - Otherwise next cycle RegWrite=rf_enable=0 and RW/WD hold their previous values.
- Latency: a push into an empty queue with rf_busy=0 is committed on RegWrite in cycle N+1 (push and pop in the same cycle bypass, count unchanged).
- Full with a simultaneous pop: push is allowed; count unchanged.
- rf_busy held high: queue fills to DEPTH, then both readies go low. No entry is lost or reordered.
- Ordering: commits leave in acceptance order. A later write to the same rd commits after the earlier one.
- flush=1: pushes blocked (both readies 0), queue emptied at the clock edge, and no RegWrite next cycle. flush has priority over push and pop.
- Forwarding: the hit compares fwd_rx against all valid queue entries plus the registered RW while RegWrite=1. The youngest match wins. fwd_rx=0 never hits. Hit and data are combinational.
- wb_count wraps never: it ranges 0..DEPTH. The pointers wrap modulo DEPTH.

Optional Feature:
- Macro WB_FORWARD_EN.
- Defined: forwarding compare logic as described above.
- Undefined: fwd_a_hit=fwd_b_hit=0 and fwd_a_data=fwd_b_data=0 constantly; ports remain present and fwd_ra/fwd_rb are unused.

Decomposition:
- Shared package: DATA_W/ADDR_W constants, the R0 address constant, a wb_entry typedef (rd, data), and the arbiter state enum (MEM_PRI, ALU_PRI).
- One natural sub-module, wb_commit_fifo: the parameterised queue holding storage, pointers, count, full/empty, flush, and the entry-valid vector exported for the forwarding compare.
- Arbitration, the output registers and forwarding stay in the top level.

Test Plan:
- Single write: alu_valid, rd=5, data=16'h1234, rf_busy=0 → alu_ready=1 the same cycle; next cycle RegWrite=1, RW=5, WD=16'h1234, then RegWrite=0; wb_empty returns to 1.
- Contention: alu (rd=2, 16'h0AAA) and mem (rd=3, 16'h0BBB) valid together for 2 cycles after reset → cycle 1 grants mem, cycle 2 grants alu; commits in the order R3, then R2.
- Back-pressure: rf_busy=1 and 5 alu pushes (rd 1..5, data 16'h0001..0005) → first 4 accepted, wb_count=4, 5th ready=0; release rf_busy → 5 commits in order with no gaps.
- R0 and flush: push rd=0 → accepted, no RegWrite. Queue 3 entries with rf_busy=1, pulse flush → wb_count=0 and no RegWrite in the following cycles.
- Forwarding (WB_FORWARD_EN defined): queue rd=4/16'h1111 then rd=4/16'h2222 with rf_busy=1, fwd_ra=4 → fwd_a_hit=1, fwd_a_data=16'h2222; fwd_rb=0 → fwd_b_hit=0. With the macro undefined: both hits 0.
- Async reset mid-drain: assert rst low between clock edges with 2 entries queued → RegWrite, RW, WD and wb_count drop to 0 immediately; after release, no stale commit occurs.

Source files
------------

// File: rtl/wb_commit_unit_pkg.sv
// Shared types and constants for the write-back commit unit.
package wb_commit_unit_pkg;
  localparam int WB_DATA_W = 16;
  localparam int WB_ADDR_W = 3;
  localparam logic [WB_ADDR_W-1:0] R0 = '0;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {MEM_PRI = 1'b0, ALU_PRI = 1'b1} arb_state_e;
endpackage

// File: rtl/wb_commit_unit_if.sv
// Result handshakes from the ALU and load paths into the commit unit.
interface wb_commit_unit_if
  import wb_commit_unit_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  alu_ready, mem_ready
    );
    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output alu_ready, mem_ready
    );
endinterface

// File: rtl/wb_commit_unit_fifo.sv
// In-order commit queue; exports slot contents and valid bits for forwarding.
module wb_commit_fifo
  import wb_commit_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wb_entry_t             push_entry,
    input  logic                  pop,
    input  logic                  flush,
    output wb_entry_t             head,
    output wb_entry_t [DEPTH-1:0] entries,
    output logic [DEPTH-1:0]      entry_valid,
    output logic [PTR_W-1:0]      rd_ptr,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty
);
    logic [PTR_W-1:0] wr_ptr;

    assign head  = entries[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
            entries     <= '0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            // Pop before push so a full-queue push+pop on the same slot leaves it valid.
            if (pop) begin
                entry_valid[rd_ptr] <= 1'b0;
                rd_ptr              <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                entries[wr_ptr]     <= push_entry;
                entry_valid[wr_ptr] <= 1'b1;
                wr_ptr              <= wr_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/wb_commit_unit.sv
// Write-back commit unit: arbitrates ALU/load results into the register file.
// Optional pending-value forwarding is enabled with `define WB_FORWARD_EN.
module wb_commit_unit
  import wb_commit_unit_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    wb_commit_unit_if.slave        src,
    input  logic                   rf_busy,
    input  logic                   flush,
    output logic                   RegWrite,
    output logic                   rf_enable,
    output logic [ADDR_W-1:0]      RW,
    output logic [DATA_W-1:0]      WD,
    input  logic [ADDR_W-1:0]      fwd_ra,
    input  logic [ADDR_W-1:0]      fwd_rb,
    output logic                   fwd_a_hit,
    output logic [DATA_W-1:0]      fwd_a_data,
    output logic                   fwd_b_hit,
    output logic [DATA_W-1:0]      fwd_b_data,
    output logic [$clog2(DEPTH):0] wb_count,
    output logic                   wb_empty
);
    localparam int PTR_W = $clog2(DEPTH);

    arb_state_e            arb_q;
    wb_entry_t             alu_entry, mem_entry, in_entry, head, commit_entry;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      entry_valid;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  q_full, q_empty;
    logic                  grant_mem, grant_alu, space, pop, accept, push_in, bypass, commit;

    assign alu_entry = '{rd: src.alu_rd, data: src.alu_data};
    assign mem_entry = '{rd: src.mem_rd, data: src.mem_data};

    assign grant_mem = src.mem_valid && (!src.alu_valid || arb_q == MEM_PRI);
    assign grant_alu = src.alu_valid && !grant_mem;

    assign pop   = !q_empty && !rf_busy && !flush;
    assign space = (!q_full || pop) && !flush;

    assign src.mem_ready = grant_mem && space;
    assign src.alu_ready = grant_alu && space;

    assign accept   = src.mem_ready || src.alu_ready;
    assign in_entry = grant_mem ? mem_entry : alu_entry;
    assign push_in  = accept && (in_entry.rd != R0);
    // Empty queue and free write port: commit straight from the input.
    assign bypass   = push_in && q_empty && !rf_busy;

    assign commit       = pop || bypass;
    assign commit_entry = pop ? head : in_entry;

    wb_commit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push_in && !bypass),
        .push_entry  (in_entry),
        .pop         (pop),
        .flush       (flush),
        .head        (head),
        .entries     (entries),
        .entry_valid (entry_valid),
        .rd_ptr      (rd_ptr),
        .count       (wb_count),
        .full        (q_full),
        .empty       (q_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arb_q     <= MEM_PRI;
            RegWrite  <= 1'b0;
            rf_enable <= 1'b0;
            RW        <= '0;
            WD        <= '0;
        end else begin
            RegWrite  <= commit;
            rf_enable <= commit;
            if (commit) begin
                RW <= commit_entry.rd;
                WD <= commit_entry.data;
            end
            if (accept && src.alu_valid && src.mem_valid)
                arb_q <= (arb_q == MEM_PRI) ? ALU_PRI : MEM_PRI;
        end
    end

    assign wb_empty = q_empty && !RegWrite;

`ifdef WB_FORWARD_EN
    logic [1:0][ADDR_W-1:0] fwd_addr;
    logic [1:0]             fwd_hit;
    logic [1:0][DATA_W-1:0] fwd_data;
    logic [PTR_W-1:0]       idx;

    assign fwd_addr = {fwd_rb, fwd_ra};

    // Scan oldest to youngest so the last match is the youngest pending value.
    always_comb begin
        fwd_hit  = '0;
        fwd_data = '0;
        idx      = '0;
        for (int p = 0; p < 2; p++) begin
            if (RegWrite && RW == fwd_addr[p] && fwd_addr[p] != R0) begin
                fwd_hit[p]  = 1'b1;
                fwd_data[p] = WD;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + PTR_W'(i);
                if (entry_valid[idx] && entries[idx].rd == fwd_addr[p] && fwd_addr[p] != R0) begin
                    fwd_hit[p]  = 1'b1;
                    fwd_data[p] = entries[idx].data;
                end
            end
        end
    end

    assign fwd_a_hit  = fwd_hit[0];
    assign fwd_a_data = fwd_data[0];
    assign fwd_b_hit  = fwd_hit[1];
    assign fwd_b_data = fwd_data[1];
`else
    logic fwd_unused;
    assign fwd_unused = ^{fwd_ra, fwd_rb, entries, entry_valid, rd_ptr};
    assign fwd_a_hit  = 1'b0;
    assign fwd_a_data = '0;
    assign fwd_b_hit  = 1'b0;
    assign fwd_b_data = '0;
`endif
endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit; forwarding expectations follow WB_FORWARD_EN.
module tb_wb_commit_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        rf_busy, flush;
    logic        RegWrite, rf_enable;
    logic [2:0]  RW;
    logic [15:0] WD;
    logic [2:0]  fwd_ra, fwd_rb;
    logic        fwd_a_hit, fwd_b_hit;
    logic [15:0] fwd_a_data, fwd_b_data;
    logic [2:0]  wb_count;
    logic        wb_empty;
    int          checks = 0;
    int          errors = 0;

`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    wb_commit_unit_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    wb_commit_unit #(.DATA_W(16), .ADDR_W(3), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .src        (bus.slave),
        .rf_busy    (rf_busy),
        .flush      (flush),
        .RegWrite   (RegWrite),
        .rf_enable  (rf_enable),
        .RW         (RW),
        .WD         (WD),
        .fwd_ra     (fwd_ra),
        .fwd_rb     (fwd_rb),
        .fwd_a_hit  (fwd_a_hit),
        .fwd_a_data (fwd_a_data),
        .fwd_b_hit  (fwd_b_hit),
        .fwd_b_data (fwd_b_data),
        .wb_count   (wb_count),
        .wb_empty   (wb_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_alu(input logic [2:0] rd, input logic [15:0] d);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = rd;
        bus.alu_data  = d;
        step();
        bus.alu_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rf_busy = 1'b0; flush = 1'b0; fwd_ra = '0; fwd_rb = '0;
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
        #2;
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_rw", RW, 0);
        chk("rst_wd", WD, 0);
        chk("rst_count", wb_count, 0);
        chk("rst_empty", wb_empty, 1);
        @(posedge clk); #1 rst = 1'b1;

        // Single write with same-cycle bypass
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd5; bus.alu_data = 16'h1234;
        #1;
        chk("single_alu_ready", bus.alu_ready, 1);
        chk("single_mem_ready", bus.mem_ready, 0);
        step();
        bus.alu_valid = 1'b0;
        chk("single_regwrite", RegWrite, 1);
        chk("single_rf_enable", rf_enable, 1);
        chk("single_rw", RW, 5);
        chk("single_wd", WD, 16'h1234);
        chk("single_empty_busy", wb_empty, 0);
        step();
        chk("single_regwrite_off", RegWrite, 0);
        chk("single_rw_hold", RW, 5);
        chk("single_empty", wb_empty, 1);

        // Contention: mem first, then alu
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd2; bus.alu_data = 16'h0AAA;
        bus.mem_valid = 1'b1; bus.mem_rd = 3'd3; bus.mem_data = 16'h0BBB;
        #1;
        chk("cont1_mem_ready", bus.mem_ready, 1);
        chk("cont1_alu_ready", bus.alu_ready, 0);
        step();
        chk("cont2_alu_ready", bus.alu_ready, 1);
        chk("cont2_mem_ready", bus.mem_ready, 0);
        chk("cont_commit1_rw", RW, 3);
        chk("cont_commit1_wd", WD, 16'h0BBB);
        step();
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
        chk("cont_commit2_we", RegWrite, 1);
        chk("cont_commit2_rw", RW, 2);
        chk("cont_commit2_wd", WD, 16'h0AAA);
        step();
        chk("cont_idle", RegWrite, 0);

        // Back-pressure: 4 fit, the 5th waits
        rf_busy = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            bus.alu_valid = 1'b1; bus.alu_rd = 3'(i); bus.alu_data = 16'(i);
            #1;
            chk($sformatf("bp_ready_%0d", i), bus.alu_ready, (i <= 4) ? 1 : 0);
            step();
        end
        chk("bp_count_full", wb_count, 4);
        chk("bp_no_write", RegWrite, 0);
        rf_busy = 1'b0;
        #1;
        chk("bp_full_pop_ready", bus.alu_ready, 1);
        step();
        bus.alu_valid = 1'b0;
        chk("bp_count_hold", wb_count, 4);
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("bp_drain_we_%0d", k), RegWrite, 1);
            chk($sformatf("bp_drain_rw_%0d", k), RW, k);
            chk($sformatf("bp_drain_wd_%0d", k), WD, k);
            step();
        end
        chk("bp_drained_we", RegWrite, 0);
        chk("bp_drained_count", wb_count, 0);

        // R0 accepted, never written
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd0; bus.alu_data = 16'hFFFF;
        #1;
        chk("r0_ready", bus.alu_ready, 1);
        step();
        bus.alu_valid = 1'b0;
        chk("r0_no_write", RegWrite, 0);
        chk("r0_count", wb_count, 0);

        // Flush with three queued
        rf_busy = 1'b1;
        push_alu(3'd6, 16'h0006);
        push_alu(3'd7, 16'h0007);
        push_alu(3'd1, 16'h0001);
        chk("flush_pre_count", wb_count, 3);
        flush = 1'b1;
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd2; bus.alu_data = 16'h0002;
        #1;
        chk("flush_alu_ready", bus.alu_ready, 0);
        step();
        flush = 1'b0; bus.alu_valid = 1'b0; rf_busy = 1'b0;
        chk("flush_count", wb_count, 0);
        chk("flush_no_write", RegWrite, 0);
        step();
        chk("flush_no_write2", RegWrite, 0);
        chk("flush_empty", wb_empty, 1);

        // Forwarding
        rf_busy = 1'b1;
        push_alu(3'd4, 16'h1111);
        push_alu(3'd4, 16'h2222);
        fwd_ra = 3'd4; fwd_rb = 3'd0;
        #1;
        chk("fwd_a_hit_q", fwd_a_hit, FWD);
        chk("fwd_a_data_q", fwd_a_data, FWD ? 16'h2222 : 16'h0);
        chk("fwd_b_r0", fwd_b_hit, 0);
        fwd_rb = 3'd2;
        #1;
        chk("fwd_b_miss", fwd_b_hit, 0);
        rf_busy = 1'b0;
        step();
        chk("fwd_a_youngest", fwd_a_data, FWD ? 16'h2222 : 16'h0);
        fwd_rb = 3'd4;
        step();
        #1;
        chk("fwd_b_rw_hit", fwd_b_hit, FWD);
        chk("fwd_b_rw_data", fwd_b_data, FWD ? 16'h2222 : 16'h0);
        step();
        chk("fwd_a_gone", fwd_a_hit, 0);
        fwd_ra = 3'd0; fwd_rb = 3'd0;

        // Async reset mid-drain
        rf_busy = 1'b1;
        push_alu(3'd1, 16'hAAAA);
        push_alu(3'd2, 16'hBBBB);
        rf_busy = 1'b0;
        step();
        chk("ar_pre_we", RegWrite, 1);
        #2 rst = 1'b0;
        #1;
        chk("ar_we", RegWrite, 0);
        chk("ar_en", rf_enable, 0);
        chk("ar_rw", RW, 0);
        chk("ar_wd", WD, 0);
        chk("ar_count", wb_count, 0);
        #2 rst = 1'b1;
        step();
        chk("ar_no_stale", RegWrite, 0);
        step();
        chk("ar_no_stale2", RegWrite, 0);
        chk("ar_empty", wb_empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
